seq101_window_counter: RTL

Downstream consumer of the serial "101" detector's one-cycle `z` hit pulses. It counts hits over fixed, back-to-back windows of `WINDOW` clock cycles. At each window end it publishes the count, with a threshold alarm and a saturation flag, through a single-entry valid/ready output register. It lets the control side read detection rate instead of raw pulses.

---
 rtl/seq101_window_counter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seq101_window_counter.sv
`timescale 1ns/1ps
// seq101_window_counter
//
// Counts the one-cycle hit pulses coming out of the serial "101" detector
// over fixed, back-to-back windows of WINDOW cycles. At each window end it
// publishes the count through a single-entry valid/ready result register.
// The published result carries an alarm (count reached THRESH) and a
// saturation flag. When a result has to be dropped, a sticky overrun flag
// is raised.
//
// Parameters:
//   WINDOW  window length in clock cycles (>= 2)
//   CW      count width
//   THRESH  alarm threshold (<= 2^CW-1)
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   en         window enable; dropping it mid-window aborts the window
//   z          hit pulse, one hit per cycle high
//   cnt        published hit count of the last completed window
//   cnt_valid  cnt/alarm/sat hold a result not yet taken
//   cnt_ready  consumer accepts the result
//   alarm      published cnt >= THRESH
//   sat        published count saturated at 2^CW-1
//   overrun    sticky; a window result was dropped (cleared only by rst)

module seq101_window_counter #(
  parameter int WINDOW = 16,
  parameter int CW     = 8,
  parameter int THRESH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          z,
  output logic [CW-1:0] cnt,
  output logic          cnt_valid,
  input  logic          cnt_ready,
  output logic          alarm,
  output logic          sat,
  output logic          overrun
);

  localparam int            TW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] THRESH_V = CW'(THRESH);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] t;
  logic [CW-1:0] acc;
  logic          sat_seen;

  logic [CW-1:0] f;
  logic          clamp;
  logic          in_count;
  logic          window_end;
  logic          load_result;
  logic          drop_result;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The enable alone moves the block in and out of
  // counting. An abort in COUNT simply returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en)  next_state = COUNT;
      COUNT:   if (!en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-edge decode. f is the window total including this edge's hit,
  // clamped at CNT_MAX. clamp marks an edge where a hit was lost to
  // saturation. A window-end result either loads (the slot is empty or is
  // being emptied on this same edge) or is dropped.
  always_comb begin
    clamp       = z && (acc == CNT_MAX);
    f           = clamp ? CNT_MAX : acc + CW'(z);
    in_count    = (state == COUNT) && en;
    window_end  = in_count && (t == T_LAST);
    load_result = window_end && (!cnt_valid || cnt_ready);
    drop_result = window_end && cnt_valid && !cnt_ready;
  end

  // Window timer and accumulator. Both clear at window end, so the next
  // window starts on the following edge with no gap. Outside an active
  // window they are held at zero, which discards an aborted count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t        <= '0;
      acc      <= '0;
      sat_seen <= 1'b0;
    end else if (in_count) begin
      if (window_end) begin
        t        <= '0;
        acc      <= '0;
        sat_seen <= 1'b0;
      end else begin
        t        <= t + 1'b1;
        acc      <= f;
        sat_seen <= sat_seen | clamp;
      end
    end else begin
      t        <= '0;
      acc      <= '0;
      sat_seen <= 1'b0;
    end
  end

  // Single-entry result register with valid/ready handshake. A load takes
  // priority over the transfer-clear, so a transfer and a new window end
  // on the same edge leave cnt_valid high with the new result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cnt_valid <= 1'b0;
      alarm     <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_result) begin
        cnt       <= f;
        alarm     <= (f >= THRESH_V);
        sat       <= sat_seen | clamp;
        cnt_valid <= 1'b1;
      end else if (cnt_valid && cnt_ready) begin
        cnt_valid <= 1'b0;
      end
      if (drop_result) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
